// File: rtl/rsc_decoder_pkg.sv
// Shared definitions for the 8-state LTE constituent RSC code: block sizes,
// decoder FSM encodings and the polynomial taps also used by the encoder.
package rsc_pkg;

    localparam int unsigned K_SMALL  = 1056;
    localparam int unsigned K_LARGE  = 6144;
    localparam int unsigned TAIL_LEN = 3;
    localparam int unsigned CNT_W    = 13;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DATA = 2'd1;
    localparam logic [1:0] S_TAIL = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Tap masks over the state vector {q2,q1,q0}; bit 0 is q0 (the D term).
    // g0 = 1+D^2+D^3 feedback uses q1,q2; g1 = 1+D+D^3 parity uses q0,q2.
    localparam logic [2:0] FB_TAPS  = 3'b110;
    localparam logic [2:0] PAR_TAPS = 3'b101;

    function automatic logic tap_xor(input logic [2:0] st, input logic [2:0] taps);
        return ^(st & taps);
    endfunction

endpackage

// File: rtl/rsc_decoder_trellis.sv
// 3-bit RSC trellis register with clear and data/tail mode; produces the
// next state, the expected parity bit and the expected tail systematic bit.
module rsc_trellis (
    input  logic       clk,
    input  logic       aclr,
    input  logic       clear,
    input  logic       advance,
    input  logic       tail_mode,
    input  logic       xk,
    output logic [2:0] next_state,
    output logic       exp_z,
    output logic       exp_x_tail
);
    import rsc_pkg::*;

    logic [2:0] st;
    logic       fb;
    logic       s;

    always_comb begin
        fb         = tap_xor(st, FB_TAPS);
        exp_x_tail = fb;
        // In tail mode the systematic bit cancels the feedback, so s is 0.
        s          = tail_mode ? 1'b0 : (xk ^ fb);
        exp_z      = s ^ tap_xor(st, PAR_TAPS);
        next_state = {st[1], st[0], s};
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            st <= '0;
        end else if (clear) begin
            st <= '0;
        end else if (advance) begin
            st <= next_state;
        end
    end

endmodule

// File: rtl/rsc_decoder.sv
// Hard-decision RSC decoder/checker: forwards systematic data bits, counts
// parity mismatches over data and tail, and verifies trellis termination.
module rsc_decoder #(
    parameter int unsigned K_SMALL  = rsc_pkg::K_SMALL,
    parameter int unsigned K_LARGE  = rsc_pkg::K_LARGE,
    parameter int unsigned TAIL_LEN = rsc_pkg::TAIL_LEN
) (
    input  logic        clk,
    input  logic        aclr,
    input  logic        start,
    input  logic        K,
    input  logic        in_valid,
    input  logic        xk,
    input  logic        zk,
    output logic        dk,
    output logic        dk_valid,
    output logic        parity_err,
    output logic        busy,
    output logic        done,
    output logic [12:0] err_count,
    output logic        tail_ok
);
    import rsc_pkg::*;

    logic [1:0]       state;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] blk_len;
    logic             in_data;
    logic             in_tail;
    logic             accept;
    logic             mism;
    logic             last_data;
    logic             last_tail;
    logic [2:0]       nxt_st;
    logic             exp_z;
    logic             exp_x_tail;

    rsc_trellis u_trellis (
        .clk       (clk),
        .aclr      (aclr),
        .clear     (start),
        .advance   (accept),
        .tail_mode (in_tail),
        .xk        (xk),
        .next_state(nxt_st),
        .exp_z     (exp_z),
        .exp_x_tail(exp_x_tail)
    );

    always_comb begin
        in_data   = (state == S_DATA);
        in_tail   = (state == S_TAIL);
        accept    = in_valid & (in_data | in_tail) & ~start;
        mism      = zk ^ exp_z;
        last_data = (bit_cnt == blk_len - 1'b1);
        last_tail = (bit_cnt == CNT_W'(TAIL_LEN - 1));
        busy      = in_data | in_tail;
        done      = (state == S_DONE);
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            blk_len    <= '0;
            err_count  <= '0;
            tail_ok    <= 1'b0;
            dk         <= 1'b0;
            dk_valid   <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            dk_valid   <= 1'b0;
            parity_err <= 1'b0;
            if (start) begin
                // Restart from any state, including abort of a running block.
                state     <= S_DATA;
                blk_len   <= K ? CNT_W'(K_LARGE) : CNT_W'(K_SMALL);
                bit_cnt   <= '0;
                err_count <= '0;
                tail_ok   <= 1'b1;
            end else begin
                case (state)
                    S_DATA: begin
                        if (accept) begin
                            dk         <= xk;
                            dk_valid   <= 1'b1;
                            parity_err <= mism;
                            err_count  <= err_count + {{(CNT_W-1){1'b0}}, mism};
                            if (last_data) begin
                                state   <= S_TAIL;
                                bit_cnt <= '0;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                    S_TAIL: begin
                        if (accept) begin
                            parity_err <= mism;
                            err_count  <= err_count + {{(CNT_W-1){1'b0}}, mism};
                            if (xk != exp_x_tail) begin
                                tail_ok <= 1'b0;
                            end
                            if (last_tail) begin
                                state   <= S_DONE;
                                bit_cnt <= '0;
                                if (nxt_st != 3'b000) begin
                                    tail_ok <= 1'b0;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                    S_DONE:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rsc_decoder.sv
// Randomized self-checking bench for rsc_decoder against a bit-level
// encoder/decoder reference model built from the code's trellis equations.
module tb_rsc_decoder;

    localparam int KS = 1056;
    localparam int KL = 6144;
    localparam int TL = 3;

    logic        clk = 1'b0;
    logic        aclr = 1'b1;
    logic        start = 1'b0;
    logic        K = 1'b0;
    logic        in_valid = 1'b0;
    logic        xk = 1'b0;
    logic        zk = 1'b0;
    logic        dk;
    logic        dk_valid;
    logic        parity_err;
    logic        busy;
    logic        done;
    logic [12:0] err_count;
    logic        tail_ok;

    rsc_decoder #(.K_SMALL(KS), .K_LARGE(KL), .TAIL_LEN(TL)) dut (
        .clk       (clk),
        .aclr      (aclr),
        .start     (start),
        .K         (K),
        .in_valid  (in_valid),
        .xk        (xk),
        .zk        (zk),
        .dk        (dk),
        .dk_valid  (dk_valid),
        .parity_err(parity_err),
        .busy      (busy),
        .done      (done),
        .err_count (err_count),
        .tail_ok   (tail_ok)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Stimulus / reference storage
    bit src [KL];
    bit tx_x[KL+TL];
    bit tx_z[KL+TL];
    bit exp_dk[$];
    int m_err;
    int m_tok;

    // Output monitor, sampled on the falling edge
    int   cyc = 0;
    int   start_cyc = 0;
    int   done_n = 0;
    int   done_lat = 0;
    int   perr_n = 0;
    int   perr_idx = -1;
    int   done_err = 0;
    logic done_tail = 1'b0;
    logic done_busy = 1'b0;
    bit   obs_dk[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (start) start_cyc = cyc;
        if (dk_valid) obs_dk.push_back(dk);
        if (parity_err) begin
            perr_n++;
            if (dk_valid) perr_idx = obs_dk.size() - 1;
        end
        if (done) begin
            done_n++;
            done_lat  = cyc - start_cyc;
            done_err  = int'(err_count);
            done_tail = tail_ok;
            done_busy = busy;
        end
    end

    task automatic clear_mon();
        obs_dk.delete();
        perr_n   = 0;
        perr_idx = -1;
        done_n   = 0;
    endtask

    task automatic gen_src(input int k, input bit zero);
        for (int i = 0; i < k; i++) src[i] = zero ? 1'b0 : 1'($urandom_range(0, 1));
    endtask

    // Encoder: systematic out, feedback g0 = 1+D^2+D^3, parity g1 = 1+D+D^3.
    task automatic model_encode(input int k);
        bit q0, q1, q2, s;
        q0 = 0; q1 = 0; q2 = 0;
        for (int i = 0; i < k + TL; i++) begin
            if (i < k) begin
                tx_x[i] = src[i];
                s = src[i] ^ q1 ^ q2;
            end else begin
                tx_x[i] = q1 ^ q2;
                s = 1'b0;
            end
            tx_z[i] = s ^ q0 ^ q2;
            q2 = q1; q1 = q0; q0 = s;
        end
    endtask

    // Receiver check on whatever sits in tx_x/tx_z (possibly corrupted).
    task automatic model_decode(input int k, output int err, output int tok);
        bit q0, q1, q2, s, ez;
        q0 = 0; q1 = 0; q2 = 0; err = 0; tok = 1;
        for (int i = 0; i < k + TL; i++) begin
            if (i < k) begin
                s = tx_x[i] ^ q1 ^ q2;
            end else begin
                if (tx_x[i] != (q1 ^ q2)) tok = 0;
                s = 1'b0;
            end
            ez = s ^ q0 ^ q2;
            if (ez != tx_z[i]) err++;
            q2 = q1; q1 = q0; q0 = s;
        end
        if (q0 | q1 | q2) tok = 0;
    endtask

    task automatic pulse_start(input logic kb);
        start    = 1'b1;
        K        = kb;
        in_valid = 1'b1;
        xk       = 1'($urandom_range(0, 1));
        zk       = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic send_bits(input int lo, input int hi, input bit stall);
        for (int i = lo; i < hi; i++) begin
            if (stall) begin
                while ($urandom_range(0, 1) == 1) begin
                    in_valid = 1'b0;
                    xk = 1'($urandom_range(0, 1));
                    zk = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            end
            in_valid = 1'b1;
            xk = tx_x[i];
            zk = tx_z[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (done_n == 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        repeat (3) @(posedge clk);
        #1;
        check_val({name, "_done_cnt"}, done_n, 1);
    endtask

    task automatic check_stream(input string name);
        int bad = 0;
        check_val({name, "_dk_len"}, obs_dk.size(), exp_dk.size());
        for (int i = 0; i < obs_dk.size() && i < exp_dk.size(); i++)
            if (obs_dk[i] != exp_dk[i]) bad++;
        check_val({name, "_dk_bits"}, bad, 0);
    endtask

    task automatic run_block(input string name, input int k, input logic kb, input bit stall);
        model_decode(k, m_err, m_tok);
        exp_dk.delete();
        for (int i = 0; i < k; i++) exp_dk.push_back(tx_x[i]);
        clear_mon();
        pulse_start(kb);
        send_bits(0, k + TL, stall);
        wait_done(name, 4 * (k + TL) + 20);
        check_stream(name);
        check_val({name, "_err"}, done_err, m_err);
        check_val({name, "_tail_ok"}, 32'(done_tail), m_tok);
        check_val({name, "_perr_pulses"}, perr_n, m_err);
        check_val({name, "_busy_at_done"}, 32'(done_busy), 0);
        if (!stall) check_val({name, "_latency"}, done_lat, k + TL + 1);
    endtask

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_dk", 32'(dk), 0);
        check_val("rst_dk_valid", 32'(dk_valid), 0);
        check_val("rst_parity_err", 32'(parity_err), 0);
        check_val("rst_busy", 32'(busy), 0);
        check_val("rst_done", 32'(done), 0);
        check_val("rst_err_count", 32'(err_count), 0);
        check_val("rst_tail_ok", 32'(tail_ok), 0);
        aclr = 1'b0;
        @(posedge clk); #1;

        // All-zero small block
        gen_src(KS, 1'b1);
        model_encode(KS);
        run_block("zero", KS, 1'b0, 1'b0);
        check_val("zero_err_const", done_err, 0);
        check_val("zero_tail_const", 32'(done_tail), 1);

        // Encoder loopback, large block
        gen_src(KL, 1'b0);
        model_encode(KL);
        run_block("loop", KL, 1'b1, 1'b0);
        check_val("loop_err_const", done_err, 0);

        // Single impulse with parity flipped at bit 5
        gen_src(KS, 1'b0);
        src[0] = 1'b1;
        model_encode(KS);
        check_val("imp_first_z", 32'(tx_z[0]), 1);
        tx_z[5] = ~tx_z[5];
        run_block("imp", KS, 1'b0, 1'b0);
        check_val("imp_err_const", done_err, 1);
        check_val("imp_perr_idx", perr_idx, 5);

        // Tail corruption: second tail systematic bit inverted
        gen_src(KS, 1'b0);
        model_encode(KS);
        tx_x[KS + 1] = ~tx_x[KS + 1];
        run_block("tailbad", KS, 1'b0, 1'b0);
        check_val("tailbad_tail_const", 32'(done_tail), 0);

        // Random 50% stalls
        gen_src(KS, 1'b0);
        model_encode(KS);
        run_block("stall", KS, 1'b0, 1'b1);

        // Restart at bit 400: abort a large block, run a small one
        gen_src(KL, 1'b0);
        model_encode(KL);
        exp_dk.delete();
        for (int i = 0; i < 400; i++) exp_dk.push_back(tx_x[i]);
        clear_mon();
        pulse_start(1'b1);
        send_bits(0, 400, 1'b0);
        check_val("rs_busy_mid", 32'(busy), 1);
        gen_src(KS, 1'b0);
        model_encode(KS);
        model_decode(KS, m_err, m_tok);
        for (int i = 0; i < KS; i++) exp_dk.push_back(tx_x[i]);
        pulse_start(1'b0);
        send_bits(0, KS + TL, 1'b0);
        wait_done("rs", 4 * KS);
        check_stream("rs");
        check_val("rs_err", done_err, m_err);
        check_val("rs_tail_ok", 32'(done_tail), m_tok);
        check_val("rs_latency", done_lat, KS + TL + 1);

        // Asynchronous clear at bit 700
        gen_src(KL, 1'b0);
        model_encode(KL);
        clear_mon();
        pulse_start(1'b1);
        send_bits(0, 700, 1'b0);
        aclr = 1'b1;
        @(posedge clk); #1;
        check_val("aclr_dk", 32'(dk), 0);
        check_val("aclr_dk_valid", 32'(dk_valid), 0);
        check_val("aclr_parity_err", 32'(parity_err), 0);
        check_val("aclr_busy", 32'(busy), 0);
        check_val("aclr_done", 32'(done), 0);
        check_val("aclr_err_count", 32'(err_count), 0);
        check_val("aclr_tail_ok", 32'(tail_ok), 0);
        aclr = 1'b0;
        clear_mon();
        for (int i = 0; i < 50; i++) begin
            in_valid = 1'b1;
            xk = 1'($urandom_range(0, 1));
            zk = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        check_val("aclr_no_done", done_n, 0);
        check_val("aclr_no_dk", obs_dk.size(), 0);
        check_val("aclr_idle_busy", 32'(busy), 0);

        // Recovery after clear
        gen_src(KS, 1'b0);
        model_encode(KS);
        run_block("recov", KS, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
